// File: rtl/toggle_cell.sv
// Single-bit T flip-flop: inverts on a rising clk edge when t is high,
// and loads its reset value asynchronously while rst is high.
module toggle_cell #(
  parameter logic RESET_VALUE = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic t,
  output logic q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= RESET_VALUE;
    end else begin
      q <= q ^ t;
    end
  end

endmodule

// File: rtl/toggle.sv
// Bank of WIDTH independent T flip-flops sharing one clock and async reset.
// qbar is derived combinationally so it can never disagree with q.
module toggle #(
  parameter int               WIDTH       = 1,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] t,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qbar
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    toggle_cell #(
      .RESET_VALUE(RESET_VALUE[i])
    ) u_cell (
      .clk(clk),
      .rst(rst),
      .t  (t[i]),
      .q  (q[i])
    );
  end

  assign qbar = ~q;

endmodule

// File: tb/tb_toggle.sv
// Bench for toggle: a default single-bit instance and a 4-bit instance with
// a non-zero reset value, checked against a toggle-count model every cycle.
module tb_toggle;

  localparam logic [3:0] RV4 = 4'b1010;

  logic       clk = 1'b0;
  logic       rst1 = 1'b0;
  logic       rst4 = 1'b0;
  logic [0:0] t1 = '0;
  logic [3:0] t4 = '0;
  logic [0:0] q1, qbar1;
  logic [3:0] q4, qbar4;

  int errors = 0;
  int checks = 0;

  // clock / reset block
  always #5 clk = ~clk;

  toggle u_dut1 (
    .clk (clk),
    .rst (rst1),
    .t   (t1),
    .q   (q1),
    .qbar(qbar1)
  );

  toggle #(
    .WIDTH      (4),
    .RESET_VALUE(RV4)
  ) u_dut4 (
    .clk (clk),
    .rst (rst4),
    .t   (t4),
    .q   (q4),
    .qbar(qbar4)
  );

  // Model: each bit equals its reset value XOR the parity of the number of
  // t=1 edges it has seen since reset was last released.
  int  cnt1;
  int  cnt4[4];
  logic armed1 = 1'b0;
  logic armed4 = 1'b0;

  always @(posedge clk or posedge rst1) begin
    if (rst1) cnt1 = 0;
    else if (t1[0] === 1'b1) cnt1 = cnt1 + 1;
  end

  always @(posedge clk or posedge rst4) begin
    for (int i = 0; i < 4; i++) begin
      if (rst4) cnt4[i] = 0;
      else if (t4[i] === 1'b1) cnt4[i] = cnt4[i] + 1;
    end
  end

  function automatic logic [0:0] exp1();
    return (cnt1 % 2 == 1) ? 1'b1 : 1'b0;
  endfunction

  function automatic logic [3:0] exp4();
    logic [3:0] e;
    for (int i = 0; i < 4; i++) e[i] = RV4[i] ^ ((cnt4[i] % 2) == 1);
    return e;
  endfunction

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // scoreboard compare process, away from the active edge
  always @(negedge clk) begin
    if (armed1) begin
      check("model_q1", {3'b000, q1}, {3'b000, exp1()});
      check("model_qbar1", {3'b000, qbar1}, {3'b000, ~exp1()});
    end
    if (armed4) begin
      check("model_q4", q4, exp4());
      check("model_qbar4", qbar4, ~exp4());
    end
  end

  // driver tasks
  task automatic drive_gap();
    @(negedge clk);
    #1;
  endtask

  task automatic after_edge();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1;
    rst1 = 1'b1;
    rst4 = 1'b1;
    t1   = 1'b1;
    t4   = 4'b1111;
    #1;
    armed1 = 1'b1;
    armed4 = 1'b1;

    // reset with t=1: two edges, no toggling
    for (int i = 0; i < 2; i++) begin
      after_edge();
      check("rst_q1", {3'b0, q1}, 4'b0000);
      check("rst_qbar1", {3'b0, qbar1}, 4'b0001);
      check("rst_q4", q4, 4'b1010);
    end

    // release, hold for 3 edges
    drive_gap();
    rst1 = 1'b0;
    t1   = 1'b0;
    for (int i = 0; i < 3; i++) begin
      after_edge();
      check("hold_q1", {3'b0, q1}, 4'b0000);
      check("hold_qbar1", {3'b0, qbar1}, 4'b0001);
    end

    // divide-by-2 with t held high
    drive_gap();
    t1 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      after_edge();
      check("div_q1", {3'b0, q1}, (i % 2 == 0) ? 4'b0001 : 4'b0000);
      check("div_qbar1", {3'b0, qbar1}, (i % 2 == 0) ? 4'b0000 : 4'b0001);
    end

    // async reset between edges
    after_edge();
    check("pre_async_q1", {3'b0, q1}, 4'b0001);
    #1;
    rst1 = 1'b1;
    #1;
    check("async_q1", {3'b0, q1}, 4'b0000);
    check("async_qbar1", {3'b0, qbar1}, 4'b0001);
    #1;
    rst1 = 1'b0;
    after_edge();
    check("post_async_q1", {3'b0, q1}, 4'b0001);

    // mid-cycle t glitch with t=0 at edges
    drive_gap();
    t1 = 1'b0;
    after_edge();
    #1;
    t1 = 1'b1;
    #1;
    t1 = 1'b0;
    after_edge();
    check("glitch_q1", {3'b0, q1}, 4'b0001);

    // reset coincident with a clock edge wins over t=1
    drive_gap();
    t1 = 1'b1;
    @(posedge clk);
    rst1 = 1'b1;
    #1;
    check("coinc_q1", {3'b0, q1}, 4'b0000);
    drive_gap();
    rst1 = 1'b0;
    t1   = 1'b0;

    // 4-bit bank: independence from a non-zero reset value
    drive_gap();
    rst4 = 1'b0;
    t4   = 4'b0110;
    after_edge();
    check("bank_q4", q4, 4'b1100);
    check("bank_qbar4", qbar4, 4'b0011);
    drive_gap();
    t4 = 4'b0000;
    after_edge();
    check("bank_hold_q4", q4, 4'b1100);
    #1;
    t4 = 4'b1111;
    #1;
    t4 = 4'b0000;
    after_edge();
    check("bank_glitch_q4", q4, 4'b1100);
    drive_gap();
    t4 = 4'b1001;
    after_edge();
    check("bank_t1001_q4", q4, 4'b0101);
    drive_gap();
    t4 = 4'b0000;
    after_edge();
    drive_gap();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
